// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two byte-serial requesters, the arbiter and the RAM port.
// The arbiter connects through the slave modport; the requesters and RAM sit on the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_req;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_we;
  logic                  m0_gnt;
  logic [DATA_WIDTH-1:0] m0_rdata;

  logic                  m1_req;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_we;
  logic                  m1_gnt;
  logic [DATA_WIDTH-1:0] m1_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;
  logic                  owner;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_we,
    input  m1_req, m1_addr, m1_wdata, m1_we,
    input  mem_rdata,
    output m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    output mem_addr, mem_wdata, mem_we,
    output busy, owner
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_we,
    output m1_req, m1_addr, m1_wdata, m1_we,
    output mem_rdata,
    input  m0_gnt, m0_rdata, m1_gnt, m1_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single byte-wide RAM port: whole-transaction grants,
// round-robin on contention, and a programmable idle gap between owners.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int TURNAROUND = 1
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  localparam logic [1:0] GAP_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

  state_t                state;
  logic [1:0]            gap_cnt;
  logic                  last_owner;
  logic                  gnt0;
  logic                  gnt1;
  logic                  busy_r;
  logic                  owner_r;

  logic                  pick;
  logic                  granted;
  logic                  sel_req;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Contention goes to the port that did not own the RAM last time.
  assign pick = (bus.m0_req && bus.m1_req) ? ~last_owner : bus.m1_req;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gap_cnt    <= 2'd0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      busy_r     <= 1'b0;
      owner_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state      <= GRANT;
            owner_r    <= pick;
            last_owner <= pick;
            gnt0       <= ~pick;
            gnt1       <= pick;
            busy_r     <= 1'b1;
          end
        end
        GRANT: begin
          if (!sel_req) begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            if (TURNAROUND > 0) begin
              state   <= TURN;
              gap_cnt <= GAP_LOAD;
            end else begin
              state  <= IDLE;
              busy_r <= 1'b0;
            end
          end
        end
        TURN: begin
          if (gap_cnt == 2'd0) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 2'd1;
          end
        end
        default: begin
          state  <= IDLE;
          gnt0   <= 1'b0;
          gnt1   <= 1'b0;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign granted   = gnt0 | gnt1;
  assign sel_req   = owner_r ? bus.m1_req   : bus.m0_req;
  assign sel_we    = owner_r ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = owner_r ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = owner_r ? bus.m1_wdata : bus.m0_wdata;

  // Gating the strobe with req keeps a dropping requester from writing in its last cycle.
  assign bus.mem_addr  = granted ? sel_addr  : '0;
  assign bus.mem_wdata = granted ? sel_wdata : '0;
  assign bus.mem_we    = granted & sel_we & sel_req;

  assign bus.m0_gnt   = gnt0;
  assign bus.m1_gnt   = gnt1;
  assign bus.m0_rdata = gnt0 ? bus.mem_rdata : '0;
  assign bus.m1_rdata = gnt1 ? bus.mem_rdata : '0;
  assign bus.busy     = busy_r;
  assign bus.owner    = owner_r;

endmodule
